// File: rtl/float_div_seq.sv
// float_div_seq: sequential IEEE-754 single-precision divider S = A / B.
// Restoring division at one quotient bit per clock, round-to-nearest-even.
// Ports:
//   clk, rst (async, active-high)
//   start        request, sampled only while idle
//   A, B         dividend / divisor, captured on an accepted start
//   S            quotient, valid from done until replaced
//   overflow     result rounded past max finite, S = +/-inf
//   underflow    result below min normal, S = +/-0
//   div_by_zero  finite nonzero divided by zero
//   busy         operation in flight
//   done         one-cycle pulse, S and flags valid
module float_div_seq #(
   parameter logic [31:0] NAN_CODE = 32'h7FC00000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] S,
   output logic        overflow,
   output logic        underflow,
   output logic        div_by_zero,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE, SPEC, CALC, RND, DONE
   } state_t;

   state_t state_q, state_d;

   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] s_q, s_d;
   logic [25:0] rem_q, rem_d;
   logic [25:0] quo_q, quo_d;
   logic [4:0]  cnt_q, cnt_d;
   logic signed [9:0] exp_q, exp_d;
   logic        sign_q, sign_d;
   logic        ovf_q, ovf_d;
   logic        unf_q, unf_d;
   logic        dbz_q, dbz_d;

   // operand classification (denormals read as zero)
   logic [7:0]  ea, eb;
   logic [22:0] fa, fb;
   logic        a_zero, a_inf, a_nan;
   logic        b_zero, b_inf, b_nan;
   logic        res_sign, special;
   logic [31:0] spec_s;
   logic        spec_dbz;

   assign ea = a_q[30:23];
   assign eb = b_q[30:23];
   assign fa = a_q[22:0];
   assign fb = b_q[22:0];

   assign a_zero = (ea == 8'h00);
   assign b_zero = (eb == 8'h00);
   assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
   assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
   assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
   assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

   assign res_sign = a_q[31] ^ b_q[31];
   assign special  = a_zero | a_inf | a_nan |
                     b_zero | b_inf | b_nan;

   always_comb begin
      spec_s   = {res_sign, 31'd0};
      spec_dbz = 1'b0;
      if (a_nan || b_nan || (a_zero && b_zero) ||
          (a_inf && b_inf)) begin
         spec_s = NAN_CODE;
      end else if (a_inf) begin
         spec_s = {res_sign, 8'hFF, 23'd0};
      end else if (b_inf || a_zero) begin
         spec_s = {res_sign, 31'd0};
      end else if (b_zero) begin
         spec_s   = {res_sign, 8'hFF, 23'd0};
         spec_dbz = 1'b1;
      end
   end

   // restoring step
   logic [25:0] mb;
   logic [25:0] diff;
   logic        ge;

   assign mb   = {2'b00, 1'b1, fb};
   assign ge   = (rem_q >= mb);
   assign diff = rem_q - mb;

   // normalise and round; quo_q[25] has weight 2^0
   logic signed [9:0] e1, e2;
   logic [23:0] sig;
   logic [24:0] sum;
   logic        guard, sticky, rup;
   logic [22:0] mant;
   logic [31:0] rnd_s;
   logic        rnd_ovf, rnd_unf;

   always_comb begin
      if (quo_q[25]) begin
         sig    = quo_q[25:2];
         guard  = quo_q[1];
         sticky = quo_q[0] | (rem_q != 26'd0);
         e1     = exp_q;
      end else begin
         sig    = quo_q[24:1];
         guard  = quo_q[0];
         sticky = (rem_q != 26'd0);
         e1     = exp_q - 10'sd1;
      end
      rup = guard & (sticky | sig[0]);
      sum = {1'b0, sig} + {24'd0, rup};
      // carry out of the significand bumps the exponent
      if (sum[24]) begin
         mant = sum[23:1];
         e2   = e1 + 10'sd1;
      end else begin
         mant = sum[22:0];
         e2   = e1;
      end
      rnd_ovf = 1'b0;
      rnd_unf = 1'b0;
      if (e2 >= 10'sd255) begin
         rnd_s   = {sign_q, 8'hFF, 23'd0};
         rnd_ovf = 1'b1;
      end else if (e2 <= 10'sd0) begin
         rnd_s   = {sign_q, 31'd0};
         rnd_unf = 1'b1;
      end else begin
         rnd_s = {sign_q, e2[7:0], mant};
      end
   end

   // state register and datapath flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         exp_q   <= '0;
         sign_q  <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
         sign_q  <= sign_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         dbz_q   <= dbz_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = SPEC;
         SPEC: state_d = special ? DONE : CALC;
         CALC: if (cnt_q == 5'd25) state_d = RND;
         RND:  state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // datapath updates
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      s_d    = s_q;
      rem_d  = rem_q;
      quo_d  = quo_q;
      cnt_d  = cnt_q;
      exp_d  = exp_q;
      sign_d = sign_q;
      ovf_d  = ovf_q;
      unf_d  = unf_q;
      dbz_d  = dbz_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d   = A;
               b_d   = B;
               ovf_d = 1'b0;
               unf_d = 1'b0;
               dbz_d = 1'b0;
            end
         end
         SPEC: begin
            sign_d = res_sign;
            exp_d  = $signed({2'b00, ea}) -
                     $signed({2'b00, eb}) + 10'sd127;
            rem_d  = {2'b00, 1'b1, fa};
            quo_d  = '0;
            cnt_d  = '0;
            if (special) begin
               s_d   = spec_s;
               dbz_d = spec_dbz;
            end
         end
         CALC: begin
            quo_d = {quo_q[24:0], ge};
            rem_d = ge ? {diff[24:0], 1'b0}
                       : {rem_q[24:0], 1'b0};
            cnt_d = cnt_q + 5'd1;
         end
         RND: begin
            s_d   = rnd_s;
            ovf_d = rnd_ovf;
            unf_d = rnd_unf;
         end
         default: ;
      endcase
   end

   // outputs
   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == DONE);
   end

   assign S           = s_q;
   assign overflow    = ovf_q;
   assign underflow   = unf_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_float_div_seq.sv
// tb_float_div_seq: self-checking bench for float_div_seq.
// Directed vectors, random operands vs an arithmetic model, reset abort, held start.
module tb_float_div_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] A, B, S;
   logic        overflow, underflow, div_by_zero;
   logic        busy, done;

   int tests = 0;
   int fails = 0;

   localparam logic [31:0] QNAN = 32'h7FC00000;

   float_div_seq dut (
      .clk(clk), .rst(rst), .start(start),
      .A(A), .B(B), .S(S),
      .overflow(overflow), .underflow(underflow),
      .div_by_zero(div_by_zero),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // reference: exact quotient, RNE from the true remainder
   function automatic void ref_div(
      input  logic [31:0] a,
      input  logic [31:0] b,
      output logic [31:0] s,
      output logic [2:0]  fl,
      output int          lat
   );
      int ea, eb, e, sh;
      logic sg, za, zb, ia, ib, na, nb;
      longint ma, mb, num, sig, r;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      za = (ea == 0);
      zb = (eb == 0);
      ia = (ea == 255) && (a[22:0] == 0);
      ib = (eb == 255) && (b[22:0] == 0);
      na = (ea == 255) && (a[22:0] != 0);
      nb = (eb == 255) && (b[22:0] != 0);
      sg = a[31] ^ b[31];
      fl = 3'b000;
      lat = 2;
      if (na || nb || (za && zb) || (ia && ib))
         s = QNAN;
      else if (ia)
         s = {sg, 8'hFF, 23'd0};
      else if (ib || za)
         s = {sg, 31'd0};
      else if (zb) begin
         s = {sg, 8'hFF, 23'd0};
         fl = 3'b001;
      end else begin
         lat = 29;
         ma = longint'({1'b1, a[22:0]});
         mb = longint'({1'b1, b[22:0]});
         e = ea - eb + 127;
         sh = 23;
         if (ma < mb) begin
            e = e - 1;
            sh = 24;
         end
         num = ma << sh;
         sig = num / mb;
         r = num % mb;
         if (2 * r > mb || (2 * r == mb && sig[0]))
            sig = sig + 1;
         if (sig == (longint'(1) << 24)) begin
            sig = sig >> 1;
            e = e + 1;
         end
         if (e >= 255) begin
            s = {sg, 8'hFF, 23'd0};
            fl = 3'b100;
         end else if (e <= 0) begin
            s = {sg, 31'd0};
            fl = 3'b010;
         end else
            s = {sg, e[7:0], sig[22:0]};
      end
   endfunction

   function automatic logic [31:0] gen_op();
      int c;
      logic [31:0] v;
      c = $urandom_range(0, 19);
      v = $urandom;
      case (c)
         0: v[30:0] = 31'd0;
         1: v[30:23] = 8'h00;
         2: v[30:0] = {8'hFF, 23'd0};
         3: begin
            v[30:23] = 8'hFF;
            v[22] = 1'b1;
         end
         4, 5, 6: v[30:23] = 8'($urandom_range(1, 254));
         default: v[30:23] = 8'($urandom_range(100, 154));
      endcase
      return v;
   endfunction

   task automatic do_op(
      input  logic [31:0] a,
      input  logic [31:0] b,
      output logic [31:0] s,
      output logic [2:0]  fl,
      output int          lat,
      output logic        bz
   );
      @(negedge clk);
      A = a;
      B = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A = $urandom;
      B = $urandom;
      lat = 1;
      while (done !== 1'b1 && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      s = S;
      fl = {overflow, underflow, div_by_zero};
      bz = busy;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      A = '0;
      B = '0;
      repeat (3) @(negedge clk);
      tests++;
      if (S !== 32'd0 || busy !== 1'b0 || done !== 1'b0 ||
          {overflow, underflow, div_by_zero} !== 3'b000) begin
         fails++;
         $display("FAIL reset: S=%h busy=%b done=%b fl=%b req S=0 all 0",
                  S, busy, done,
                  {overflow, underflow, div_by_zero});
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [31:0] va[9], vb[9], vs[9];
      logic [2:0]  vf[9];
      int          vl[9];
      logic [31:0] s;
      logic [2:0]  fl;
      int          lat;
      logic        bz;
      va = '{32'h40C00000, 32'h3F800000, 32'h3F800000,
             32'h00000000, 32'h7F800000, 32'h7F7FFFFF,
             32'h00800000, 32'h00000001, 32'hC0C00000};
      vb = '{32'h40000000, 32'h40400000, 32'h00000000,
             32'h00000000, 32'h7F800000, 32'h00800000,
             32'h40000000, 32'h7F800000, 32'h40000000};
      vs = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000,
             32'h7FC00000, 32'h7FC00000, 32'h7F800000,
             32'h00000000, 32'h00000000, 32'hC0400000};
      vf = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000,
             3'b100, 3'b010, 3'b000, 3'b000};
      vl = '{29, 29, 2, 2, 2, 29, 29, 2, 29};
      for (int i = 0; i < 9; i++) begin
         do_op(va[i], vb[i], s, fl, lat, bz);
         tests++;
         if (s !== vs[i] || fl !== vf[i] || lat != vl[i] ||
             bz !== 1'b1) begin
            fails++;
            $display("FAIL directed %0d: S=%h fl=%b lat=%0d busy=%b req S=%h fl=%b lat=%0d busy=1",
                     i, s, fl, lat, bz, vs[i], vf[i], vl[i]);
         end
      end
      repeat (4) @(negedge clk);
      tests++;
      if (S !== 32'hC0400000 || busy !== 1'b0) begin
         fails++;
         $display("FAIL hold: S=%h busy=%b req S=c0400000 busy=0",
                  S, busy);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, s, es;
      logic [2:0]  fl, ef;
      int          lat, el;
      logic        bz;
      for (int i = 0; i < 300; i++) begin
         a = gen_op();
         b = gen_op();
         if ($urandom_range(0, 7) == 0)
            b[22:0] = a[22:0];
         ref_div(a, b, es, ef, el);
         do_op(a, b, s, fl, lat, bz);
         tests++;
         if (s !== es || fl !== ef || lat != el) begin
            fails++;
            $display("FAIL random %h/%h: S=%h fl=%b lat=%0d req S=%h fl=%b lat=%0d",
                     a, b, s, fl, lat, es, ef, el);
         end
      end
   endtask

   task automatic test_abort();
      int          nd;
      logic [31:0] s;
      logic [2:0]  fl;
      int          lat;
      logic        bz;
      @(negedge clk);
      A = 32'h40C00000;
      B = 32'h40000000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      tests++;
      if (busy !== 1'b0 || S !== 32'd0 || done !== 1'b0 ||
          {overflow, underflow, div_by_zero} !== 3'b000) begin
         fails++;
         $display("FAIL abort: busy=%b S=%h done=%b req busy=0 S=0 done=0",
                  busy, S, done);
      end
      @(negedge clk);
      rst = 1'b0;
      nd = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) nd++;
      end
      tests++;
      if (nd != 0) begin
         fails++;
         $display("FAIL abort_done: dones=%0d req 0", nd);
      end
      do_op(32'h40C00000, 32'h40000000, s, fl, lat, bz);
      tests++;
      if (s !== 32'h40400000 || fl !== 3'b000 || lat != 29) begin
         fails++;
         $display("FAIL after_abort: S=%h fl=%b lat=%0d req S=40400000 fl=000 lat=29",
                  s, fl, lat);
      end
   endtask

   task automatic test_back_to_back();
      int n, cyc, last, nd;
      @(negedge clk);
      A = 32'h40C00000;
      B = 32'h40000000;
      start = 1'b1;
      n = 0;
      cyc = 0;
      last = 0;
      while (n < 3 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (done === 1'b1) begin
            n++;
            tests++;
            if (S !== 32'h40400000 ||
                (cyc - last) != (n == 1 ? 29 : 30)) begin
               fails++;
               $display("FAIL b2b %0d: S=%h gap=%0d req S=40400000 gap=%0d",
                        n, S, cyc - last, (n == 1 ? 29 : 30));
            end
            last = cyc;
            if (n == 3) start = 1'b0;
         end
      end
      start = 1'b0;
      tests++;
      if (n != 3) begin
         fails++;
         $display("FAIL b2b_count: dones=%0d req 3", n);
      end
      nd = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) nd++;
      end
      tests++;
      if (nd != 0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL b2b_tail: dones=%0d busy=%b req 0 0", nd, busy);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_abort();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
